// File: rtl/frame_pkg.sv
// Shared definitions for the frame transmit packer and the receive-side deframer.
package frame_pkg;

  // Packer sequencing states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_HDR,
    S_PAYLOAD,
    S_GAP
  } frame_state_e;

  // Header layout: sync high byte, sync low byte, length, sequence number.
  localparam int          HDR_BYTES         = 4;
  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hEB90;
  // The CRC appender needs at least this many idle cycles between frames.
  localparam int          GAP_MIN           = 3;

  // Header byte selected by its position within the header.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                          input logic [15:0] sync,
                                          input logic [7:0]  len,
                                          input logic [7:0]  seq);
    logic [7:0] b;
    case (idx)
      2'd0:    b = sync[15:8];
      2'd1:    b = sync[7:0];
      2'd2:    b = len;
      default: b = seq;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_pack_tx.sv
// Transmit frame packer: emits sync, length, sequence and payload bytes from
// a FWFT FIFO as one gap-free byte stream, then holds an idle gap for the
// downstream CRC appender.
module frame_pack_tx
  import frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
  parameter int          GAP_CYCLES = GAP_MIN   // must be >= GAP_MIN
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_len,
  input  logic [7:0] i_pl_data,
  input  logic [8:0] i_pl_count,
  output logic       o_pl_rd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_len_err,
  output logic [7:0] o_seq
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [1:0]       HDR_LAST = 2'(HDR_BYTES - 1);

  frame_state_e     state_q;
  logic [7:0]       len_q;
  logic [1:0]       idx_q;
  logic [7:0]       cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             len_err_q;
  logic [7:0]       seq_q;
  logic [7:0]       hdr_byte_d;

  // Header byte to be registered onto o_data in the current HDR cycle.
  always_comb begin
    hdr_byte_d = hdr_byte(idx_q, SYNC_WORD, len_q, seq_q);
  end

  // Read strobe is decoded, not registered, so the FIFO advances on the same
  // edge that captures its head byte into o_data.
  assign o_pl_rd = (state_q == S_PAYLOAD) && (cnt_q < len_q);

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      seq_q     <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register in this block sees
      // pre-edge values; the single-cycle pulses default low here and are
      // raised only in the branch that owns them.
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (i_len == 8'd0) begin
              len_err_q <= 1'b1;
            end else begin
              len_q   <= i_len;
              busy_q  <= 1'b1;
              state_q <= S_WAIT_DATA;
            end
          end
        end

        // Hold off until the whole payload is buffered so the frame can
        // never stall once the sync bytes have gone out.
        S_WAIT_DATA: begin
          if (i_pl_count >= {1'b0, len_q}) begin
            idx_q   <= '0;
            state_q <= S_HDR;
          end
        end

        S_HDR: begin
          data_q  <= hdr_byte_d;
          valid_q <= 1'b1;
          idx_q   <= idx_q + 2'd1;
          if (idx_q == HDR_LAST) begin
            cnt_q   <= '0;
            state_q <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          data_q  <= i_pl_data;
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            seq_q   <= seq_q + 8'd1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end
        end

        // Idle gap; the final gap cycle is also the first IDLE cycle.
        S_GAP: begin
          gap_q <= gap_q + GAP_W'(1);
          if (gap_q == GAP_LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_len_err = len_err_q;
  assign o_seq     = seq_q;

endmodule

// File: tb/tb_frame_pack_tx.sv
// Self-checking bench for frame_pack_tx: FWFT FIFO model, queue-based frame
// reference model, vector table, random frames and multi-cycle corner cases.
module tb_frame_pack_tx;

  localparam logic [15:0] SYNC     = 16'hEB90;
  localparam int          GAP      = 3;
  localparam int          BOUND    = 700;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_len;
  logic [7:0] i_pl_data;
  logic [8:0] i_pl_count;
  logic       o_pl_rd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_len_err;
  logic [7:0] o_seq;

  int n_checks = 0;
  int n_errors = 0;

  frame_pack_tx #(.SYNC_WORD(SYNC), .GAP_CYCLES(GAP)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_pl_data (i_pl_data),
    .i_pl_count(i_pl_count),
    .o_pl_rd   (o_pl_rd),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_len_err (o_len_err),
    .o_seq     (o_seq)
  );

  always #5 clk_in = ~clk_in;

  // FWFT payload FIFO: the bench pushes between edges, the DUT pops on edges.
  logic [7:0] mem [0:511];
  int head = 0;
  int tail = 0;
  assign i_pl_count = 9'(tail - head);
  assign i_pl_data  = (tail != head) ? mem[head % 512] : 8'h00;

  always @(posedge clk_in) begin
    if (o_pl_rd && (tail != head)) head <= head + 1;
  end

  // Reference model: every byte pushed, in order, plus the next sequence number.
  logic [7:0] mq[$];
  logic [7:0] seq_m = 8'd0;
  logic [7:0] last_frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[tail % 512] = b;
    tail = tail + 1;
    mq.push_back(b);
  endtask

  // Issue one request and watch it to the end of its gap. Returns on the
  // negedge of the o_done cycle (or after the error window for len==0).
  task automatic do_frame(input int len, input int prefill, input int late,
                          input int delay, input bit hold, input int exp_first,
                          input bit exp_err, input int exp_flen);
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] g;
    int first_k, rd_cnt, done_cnt, low_after, restart, err_cnt, busy_seen, act_seen;
    bit ended;
    first_k = -1; rd_cnt = 0; done_cnt = 0; low_after = 0; restart = 0;
    err_cnt = 0; busy_seen = 0; act_seen = 0; ended = 1'b0;

    for (int i = 0; i < prefill; i++) push_byte(8'($urandom));
    i_len   = 8'(len);
    i_start = 1'b1;

    if (exp_err) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk_in);
        if (k == 0) begin
          i_start = 1'b0;
          check("len_err pulse timing", o_len_err, 1);
        end
        err_cnt   += int'(o_len_err);
        busy_seen += int'(o_busy);
        act_seen  += int'(o_valid | o_pl_rd);
      end
      check("len_err pulse count", err_cnt, 1);
      check("busy on rejected request", busy_seen, 0);
      check("valid/rd on rejected request", act_seen, 0);
      check("seq unchanged after reject", o_seq, seq_m);
      return;
    end

    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk_in);
      if (k == 0 && !hold) i_start = 1'b0;
      rd_cnt  += int'(o_pl_rd);
      err_cnt += int'(o_len_err);
      if (o_valid) begin
        if (ended) restart++;
        else begin
          if (first_k < 0) first_k = k;
          got.push_back(o_data);
        end
      end else if (first_k >= 0) begin
        ended = 1'b1;
      end
      if (ended && !o_valid) low_after++;
      if (o_done) begin
        done_cnt++;
        break;
      end
      if (k == delay && late > 0)
        for (int i = 0; i < late; i++) push_byte(8'($urandom));
    end

    // Expected frame from the model.
    exp_q.push_back(SYNC[15:8]);
    exp_q.push_back(SYNC[7:0]);
    exp_q.push_back(8'(len));
    exp_q.push_back(seq_m);
    for (int i = 0; i < len; i++) exp_q.push_back((mq.size() > 0) ? mq.pop_front() : 8'hxx);

    check($sformatf("done seen len=%0d", len), done_cnt, 1);
    check($sformatf("first valid latency len=%0d", len), first_k, exp_first);
    check($sformatf("frame length len=%0d", len), got.size(), exp_flen);
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      check($sformatf("len=%0d byte%0d", len, i), g, exp_q[i]);
    end
    check($sformatf("pl_rd count len=%0d", len), rd_cnt, len);
    check($sformatf("gap low cycles len=%0d", len), low_after, GAP);
    check($sformatf("valid after frame end len=%0d", len), restart, 0);
    check($sformatf("spurious len_err len=%0d", len), err_cnt, 0);
    check($sformatf("busy low at done len=%0d", len), o_busy, 0);
    seq_m = seq_m + 8'd1;
    check($sformatf("seq after frame len=%0d", len), o_seq, seq_m);
    last_frame = got;
  endtask

  typedef struct {
    int len;
    int prefill;
    int late;
    int delay;
    int exp_first;
    bit exp_err;
    int exp_flen;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] t1_exp[7];

  initial begin
    int nv, p, avail, len, late, delay, ef;

    vecs[0] = '{len: 3, prefill: 3, late: 0, delay: 0,  exp_first: 2,  exp_err: 1'b0, exp_flen: 7};
    vecs[1] = '{len: 5, prefill: 2, late: 3, delay: 10, exp_first: 12, exp_err: 1'b0, exp_flen: 9};
    vecs[2] = '{len: 0, prefill: 0, late: 0, delay: 0,  exp_first: -1, exp_err: 1'b1, exp_flen: 0};
    vecs[3] = '{len: 1, prefill: 1, late: 0, delay: 0,  exp_first: 2,  exp_err: 1'b0, exp_flen: 5};
    vecs[4] = '{len: 8, prefill: 8, late: 0, delay: 0,  exp_first: 2,  exp_err: 1'b0, exp_flen: 12};
    vecs[5] = '{len: 4, prefill: 0, late: 4, delay: 3,  exp_first: 5,  exp_err: 1'b0, exp_flen: 8};
    t1_exp = '{8'hEB, 8'h90, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};

    // Reset state.
    rst = 1'b1; i_start = 1'b0; i_len = 8'd0;
    repeat (3) @(negedge clk_in);
    check("reset valid", o_valid, 0);
    check("reset busy", o_busy, 0);
    check("reset data", o_data, 0);
    check("reset seq", o_seq, 0);
    check("reset pl_rd", o_pl_rd, 0);
    check("reset done/len_err", {o_done, o_len_err}, 0);
    rst = 1'b0;
    @(negedge clk_in);
    check("idle after reset busy", o_busy, 0);
    check("idle after reset valid", o_valid, 0);

    // Basic frame with known payload.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    do_frame(3, 0, 0, 0, 1'b0, 2, 1'b0, 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t1 byte%0d", i), (i < last_frame.size()) ? last_frame[i] : 8'hxx, t1_exp[i]);
    check("t1 seq", o_seq, 1);

    // Vector table.
    foreach (vecs[v])
      do_frame(vecs[v].len, vecs[v].prefill, vecs[v].late, vecs[v].delay, 1'b0,
               vecs[v].exp_first, vecs[v].exp_err, vecs[v].exp_flen);

    // Randomised frames, some starved so they wait for late data.
    for (int r = 0; r < 12; r++) begin
      len   = int'($urandom_range(1, 16));
      p     = int'($urandom_range(0, len));
      avail = mq.size() + p;
      if (avail >= len) begin
        late = int'($urandom_range(0, 2)); delay = 1; ef = 2;
      end else begin
        delay = int'($urandom_range(1, 8));
        late  = len - avail + int'($urandom_range(0, 2));
        ef    = delay + 2;
      end
      do_frame(len, p, late, delay, 1'b0, ef, 1'b0, 4 + len);
    end

    // Reset during the second payload byte of a len=8 frame.
    for (int i = 0; i < 8; i++) push_byte(8'($urandom));
    i_len = 8'd8; i_start = 1'b1; nv = 0;
    for (int k = 0; k < 40 && nv < 6; k++) begin
      @(negedge clk_in);
      if (k == 0) i_start = 1'b0;
      if (o_valid) nv++;
    end
    check("reached second payload byte", nv, 6);
    rst = 1'b1;
    #1;
    check("async reset valid", o_valid, 0);
    check("async reset busy", o_busy, 0);
    check("async reset seq", o_seq, 0);
    check("async reset pl_rd", o_pl_rd, 0);
    for (int i = 0; i < nv - 4; i++) void'(mq.pop_front());
    seq_m = 8'd0;
    @(negedge clk_in);
    rst = 1'b0;
    check("fifo left after reset", i_pl_count, mq.size());
    do_frame(2, 0, 0, 0, 1'b0, 2, 1'b0, 6);

    // 256 back-to-back len=1 frames with start held high through busy.
    @(negedge clk_in); rst = 1'b1;
    @(negedge clk_in); rst = 1'b0;
    seq_m = 8'd0;
    for (int f = 0; f < 256; f++) do_frame(1, 1, 0, 0, 1'b1, 2, 1'b0, 5);
    check("seq wrapped after 256", o_seq, 0);
    do_frame(1, 1, 0, 0, 1'b0, 2, 1'b0, 5);
    check("257th frame seq byte", (last_frame.size() > 3) ? last_frame[3] : 8'hxx, 0);

    // Longest frame from a full FIFO.
    do_frame(255, 256 - mq.size(), 0, 0, 1'b0, 2, 1'b0, 259);
    check("fifo count after len=255", i_pl_count, 1);

    repeat (2) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_pack_tx.md
# frame_pack_tx

Transmit-side frame packer. On a start request it builds one frame (2 sync bytes, length, sequence number, then LEN payload bytes drawn from a first-word-fall-through payload FIFO) and emits it as a gap-free byte stream to the downstream CRC-16 appender. After each frame it enforces an idle gap so the appender can emit its two CRC bytes and re-initialise before the next frame.

## Interface
- SYNC_WORD, 16'hEB90, sync pattern; high byte is sent first.
- GAP_CYCLES, 3, minimum number of o_valid-low cycles after each frame (legal range ≥3).
- clk_in  input  1  single clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle frame request; sampled only in IDLE.
- i_len  input  8  payload byte count for the request; 0 is illegal.
- i_pl_data  input  8  FWFT FIFO head byte.
- i_pl_count  input  9  FIFO fill level (0..256).
- o_pl_rd  output  1  FIFO read strobe; consumes the current i_pl_data.
- o_data  output  8  frame byte to the CRC appender.
- o_valid  output  1  o_data qualifier; high for exactly 4+LEN consecutive cycles per frame.
- o_busy  output  1  high from start acceptance until return to IDLE.
- o_done  output  1  one-cycle pulse at the end of the gap.
- o_len_err  output  1  one-cycle pulse when a request with i_len==0 is rejected.
- o_seq  output  8  sequence number to be used by the next frame.

## Operation
- States: IDLE → WAIT_DATA → HDR → PAYLOAD → GAP → IDLE.
- IDLE:
  - i_start with i_len≠0: capture len_r, go to WAIT_DATA, set o_busy.
  - i_start with i_len==0: pulse o_len_err, stay in IDLE. o_seq is unchanged.
- WAIT_DATA: wait until i_pl_count ≥ len_r, then go to HDR. Waiting has no timeout.
  - This wait guarantees that the payload never underruns, so o_valid is never broken inside a frame. The downstream appender treats any o_valid drop as end of frame.
- HDR: send SYNC_WORD[15:8], SYNC_WORD[7:0], len_r, o_seq over four consecutive cycles, tracked by a 2-bit byte index.
- PAYLOAD:
  - Each cycle, assert o_pl_rd and register i_pl_data into o_data.
  - An 8-bit counter tracks payload bytes. After len_r bytes, go to GAP.
  - o_pl_rd is asserted exactly len_r times per frame.
- GAP:
  - o_valid stays low for GAP_CYCLES cycles.
  - o_done pulses in the last gap cycle. The state returns to IDLE on the same edge, and o_busy drops with it.
  - o_seq increments (mod 256, 255→0) on the edge that leaves PAYLOAD.
- i_start outside IDLE is ignored; requests are not queued.
- Reset values: o_data=0, o_valid=0, o_pl_rd=0, o_busy=0, o_done=0, o_len_err=0, o_seq=0, state=IDLE.
- Reset mid-frame:
  - Outputs go to their reset values immediately (asynchronously).
  - Payload already read stays consumed; remaining bytes stay in the FIFO.
  - The appender will close a truncated frame. This is accepted behaviour.

## Timing
- All outputs are registered except o_pl_rd, which is decoded combinationally from state and counter.
- Latency, with i_start sampled at edge N and enough FIFO data:
  - WAIT_DATA is evaluated at N+1.
  - The first sync byte appears on o_data/o_valid after edge N+2.
  - Each further wait cycle in WAIT_DATA adds one cycle.
- Frame duration: o_valid is high for exactly 4+len_r cycles. The first payload byte directly follows the o_seq byte.
- Minimum request-to-request spacing: 2 + 4 + len_r + GAP_CYCLES cycles. The earliest accepted i_start is in the cycle after o_done.
- FWFT contract:
  - i_pl_data is valid whenever i_pl_count>0.
  - The FIFO advances at the edge where o_pl_rd=1.
  - i_pl_count reflects the read one cycle later.
  - The WAIT_DATA check uses only the count sampled before PAYLOAD begins.

## Structure
- Shared package frame_pkg holds:
  - the state enum;
  - HDR_BYTES=4;
  - SYNC_WORD_DEFAULT=16'hEB90;
  - GAP_MIN=3.
- The downstream receive-side deframer also uses this package.
- Single module with no sub-modules. Counters and the FSM are small enough to keep flat.
- The top level wires o_data/o_valid directly into the CRC appender's byte/valid inputs.

## Test plan
- Start with len=3 and FIFO holding 0x11,0x22,0x33 → o_data sequence EB,90,03,00,11,22,33 with o_valid high for 7 cycles. Then o_valid low for 3 cycles, o_done pulses once, o_seq=1, o_pl_rd pulses 3 times.
- Start with len=5 and only 2 bytes in FIFO; 3 more bytes arrive 10 cycles later → no o_valid until count≥5, then a contiguous 9-byte frame.
- Start with len=0 → o_len_err pulses for one cycle; o_busy, o_valid and o_pl_rd stay 0; o_seq unchanged.
- Issue 256 back-to-back len=1 frames → seq byte counts 0..255, then the 257th frame carries 0x00. Every gap is exactly 3 cycles, and a start pulse held during o_busy is ignored.
- Assert rst during the 2nd payload byte of a len=8 frame → o_valid, o_busy and o_seq go to 0 immediately. A following len=2 request produces EB,90,02,00 and the next two FIFO bytes.
- Use len=255 with the FIFO at count=256 → a 259-byte contiguous frame, o_pl_rd asserted 255 times, and the remaining count is 1.
